// File: rtl/dma_path_ctrl_pkg.sv
// rtl/dma_path_ctrl_pkg.sv - opcodes, header field positions and FSM encoding for dma_path_ctrl
package dma_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h03;

  localparam int HDR_OP_MSB    = 79;
  localparam int HDR_OP_LSB    = 72;
  localparam int HDR_LEN_MSB   = 71;
  localparam int HDR_LEN_LSB   = 56;
  localparam int HDR_HADDR_MSB = 55;
  localparam int HDR_HADDR_LSB = 16;
  localparam int HDR_LADDR_MSB = 11;
  localparam int HDR_LADDR_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_GRANT   = 4'd1,
    ST_HDR     = 4'd2,
    ST_CMD     = 4'd3,
    ST_WR_DATA = 4'd4,
    ST_RD_DATA = 4'd5,
    ST_DONE    = 4'd6
  } state_t;

endpackage

// File: rtl/dma_path_ctrl_if.sv
// rtl/dma_path_ctrl_if.sv - core-side, host command and payload stream signals of dma_path_ctrl
interface dma_path_ctrl_if;
  logic         lsc_req;
  logic         lsc_resp;
  logic         lsc_wr_valid;
  logic [127:0] lsc_wr_data;
  logic         lsc_wr_ready;
  logic         lsc_rd_valid;
  logic [127:0] lsc_rd_data;
  logic         lsc_rd_ready;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_opcode;
  logic [15:0]  cmd_length;
  logic [39:0]  cmd_host_addr;
  logic [11:0]  cmd_local_addr;
  logic         c2h_valid;
  logic [127:0] c2h_data;
  logic         c2h_ready;
  logic         h2c_valid;
  logic [127:0] h2c_data;
  logic         h2c_ready;
  logic         busy;
  logic         err_opcode;

  modport slave (
    input  lsc_req, lsc_wr_valid, lsc_wr_data, lsc_rd_ready, cmd_ready,
           c2h_ready, h2c_valid, h2c_data,
    output lsc_resp, lsc_wr_ready, lsc_rd_valid, lsc_rd_data, cmd_valid,
           cmd_opcode, cmd_length, cmd_host_addr, cmd_local_addr,
           c2h_valid, c2h_data, h2c_ready, busy, err_opcode
  );

  modport master (
    output lsc_req, lsc_wr_valid, lsc_wr_data, lsc_rd_ready, cmd_ready,
           c2h_ready, h2c_valid, h2c_data,
    input  lsc_resp, lsc_wr_ready, lsc_rd_valid, lsc_rd_data, cmd_valid,
           cmd_opcode, cmd_length, cmd_host_addr, cmd_local_addr,
           c2h_valid, c2h_data, h2c_ready, busy, err_opcode
  );
endinterface

// File: rtl/dma_path_ctrl_hdr_decode.sv
// rtl/dma_path_ctrl_hdr_decode.sv - combinational split of the 128-bit command header beat
module dma_hdr_decode
  import dma_pkg::*;
(
  input  logic [127:0] i_beat,
  output logic [7:0]   o_opcode,
  output logic [15:0]  o_length,
  output logic [39:0]  o_host_addr,
  output logic [11:0]  o_local_addr,
  output logic         o_op_legal
);
  logic w_unused;

  assign o_opcode     = i_beat[HDR_OP_MSB:HDR_OP_LSB];
  assign o_length     = i_beat[HDR_LEN_MSB:HDR_LEN_LSB];
  assign o_host_addr  = i_beat[HDR_HADDR_MSB:HDR_HADDR_LSB];
  assign o_local_addr = i_beat[HDR_LADDR_MSB:HDR_LADDR_LSB];
  assign o_op_legal   = (o_opcode == OP_READ) || (o_opcode == OP_WRITE);

  // Reserved header bits carry no meaning here.
  assign w_unused = ^{i_beat[127:80], i_beat[15:12]};
endmodule

// File: rtl/dma_path_ctrl.sv
// rtl/dma_path_ctrl.sv - grants one request, decodes its header, issues the host command
// and steers the payload between the core and host streams.
module dma_path_ctrl
  import dma_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  dma_path_ctrl_if.slave  bus
);
  state_t       r_state, w_next;
  logic [7:0]   r_opcode;
  logic [15:0]  r_length, r_cnt;
  logic [39:0]  r_host;
  logic [11:0]  r_local;

  logic [7:0]   w_op;
  logic [15:0]  w_len, w_cnt_inc;
  logic [39:0]  w_host;
  logic [11:0]  w_local;
  logic         w_legal, w_hdr_hs, w_wr_hs, w_rd_hs, w_last;

  logic         w_resp, w_wr_ready, w_rd_valid, w_cmd_valid, w_c2h_valid, w_h2c_ready, w_err;
  logic [127:0] w_rd_data, w_c2h_data;

  dma_hdr_decode u_dec (
    .i_beat       (bus.lsc_wr_data),
    .o_opcode     (w_op),
    .o_length     (w_len),
    .o_host_addr  (w_host),
    .o_local_addr (w_local),
    .o_op_legal   (w_legal)
  );

  assign w_hdr_hs  = (r_state == ST_HDR) && bus.lsc_wr_valid;
  assign w_wr_hs   = (r_state == ST_WR_DATA) && bus.lsc_wr_valid && bus.c2h_ready;
  assign w_rd_hs   = (r_state == ST_RD_DATA) && bus.h2c_valid && bus.lsc_rd_ready;
  assign w_cnt_inc = r_cnt + 16'd1;
  // Compare against cnt+1 so a length of 0xFFFF terminates without the counter wrapping.
  assign w_last    = (w_cnt_inc == r_length);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_opcode <= '0;
      r_length <= '0;
      r_host   <= '0;
      r_local  <= '0;
    end else begin
      r_state <= w_next;
      if (w_hdr_hs) begin
        r_opcode <= w_op;
        r_length <= w_len;
        r_host   <= w_host;
        r_local  <= w_local;
        r_cnt    <= '0;
      end else if (w_wr_hs || w_rd_hs) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_resp      = 1'b0;
    w_wr_ready  = 1'b0;
    w_rd_valid  = 1'b0;
    w_rd_data   = '0;
    w_cmd_valid = 1'b0;
    w_c2h_valid = 1'b0;
    w_c2h_data  = '0;
    w_h2c_ready = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.lsc_req) w_next = ST_GRANT;
      ST_GRANT: begin
        w_resp = 1'b1;
        w_next = ST_HDR;
      end
      ST_HDR: begin
        w_wr_ready = 1'b1;
        if (bus.lsc_wr_valid) begin
          w_err  = ~w_legal;
          w_next = w_legal ? ST_CMD : ST_DONE;
        end
      end
      ST_CMD: begin
        w_cmd_valid = 1'b1;
        if (bus.cmd_ready) begin
          if (r_length == 16'd0)        w_next = ST_DONE;
          else if (r_opcode == OP_WRITE) w_next = ST_WR_DATA;
          else                           w_next = ST_RD_DATA;
        end
      end
      ST_WR_DATA: begin
        w_c2h_valid = bus.lsc_wr_valid;
        w_c2h_data  = bus.lsc_wr_data;
        w_wr_ready  = bus.c2h_ready;
        if (w_wr_hs && w_last) w_next = ST_DONE;
      end
      ST_RD_DATA: begin
        w_rd_valid  = bus.h2c_valid;
        w_rd_data   = bus.h2c_data;
        w_h2c_ready = bus.lsc_rd_ready;
        if (w_rd_hs && w_last) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.lsc_resp       = w_resp;
  assign bus.lsc_wr_ready   = w_wr_ready;
  assign bus.lsc_rd_valid   = w_rd_valid;
  assign bus.lsc_rd_data    = w_rd_data;
  assign bus.cmd_valid      = w_cmd_valid;
  assign bus.cmd_opcode     = w_cmd_valid ? r_opcode : 8'd0;
  assign bus.cmd_length     = w_cmd_valid ? r_length : 16'd0;
  assign bus.cmd_host_addr  = w_cmd_valid ? r_host   : 40'd0;
  assign bus.cmd_local_addr = w_cmd_valid ? r_local  : 12'd0;
  assign bus.c2h_valid      = w_c2h_valid;
  assign bus.c2h_data       = w_c2h_data;
  assign bus.h2c_ready      = w_h2c_ready;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.err_opcode     = w_err;
endmodule

// File: tb/tb_dma_path_ctrl.sv
// tb/tb_dma_path_ctrl.sv - directed bench for dma_path_ctrl
module tb_dma_path_ctrl;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dma_path_ctrl_if bus ();

  dma_path_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [7:0] op, input logic [15:0] len,
                                          input logic [39:0] host, input logic [11:0] loc);
    logic [127:0] h;
    h          = '0;
    h[127:80]  = 48'hFFFF_EEEE_DDDD;
    h[79:72]   = op;
    h[71:56]   = len;
    h[55:16]   = host;
    h[15:12]   = 4'hF;
    h[11:0]    = loc;
    return h;
  endfunction

  function automatic logic [127:0] beat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {w, w, w, w};
  endfunction

  // Ends #1 after the negedge of the HDR cycle, header beat presented.
  task automatic start(input logic [7:0] op, input logic [15:0] len,
                       input logic [39:0] host, input logic [11:0] loc);
    @(negedge clk);
    bus.lsc_req = 1'b1;
    @(negedge clk);
    #1;
    check("grant_resp", bus.lsc_resp, 1'b1);
    check("grant_err", bus.err_opcode, 1'b0);
    bus.lsc_req      = 1'b0;
    bus.lsc_wr_valid = 1'b1;
    bus.lsc_wr_data  = mk_hdr(op, len, host, loc);
    @(negedge clk);
    #1;
    check("hdr_ready", bus.lsc_wr_ready, 1'b1);
    check("hdr_resp_low", bus.lsc_resp, 1'b0);
  endtask

  task automatic after_hdr();
    @(negedge clk);
    bus.lsc_wr_valid = 1'b0;
    bus.lsc_wr_data  = '0;
    #1;
  endtask

  task automatic cmd_accept();
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
  endtask

  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int n;
    bus.lsc_req      = 1'b0;
    bus.lsc_wr_valid = 1'b0;
    bus.lsc_wr_data  = '0;
    bus.lsc_rd_ready = 1'b0;
    bus.cmd_ready    = 1'b0;
    bus.c2h_ready    = 1'b0;
    bus.h2c_valid    = 1'b0;
    bus.h2c_data     = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_resp", bus.lsc_resp, 1'b0);
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_wr_ready", bus.lsc_wr_ready, 1'b0);
    check("rst_h2c_ready", bus.h2c_ready, 1'b0);
    check("rst_rd_data", bus.lsc_rd_data, 128'd0);
    check("rst_c2h_data", bus.c2h_data, 128'd0);
    rst = 1'b0;

    // Write, length 3
    start(OP_WRITE, 16'd3, 40'h12_3456_7800, 12'h0A0);
    after_hdr();
    check("w3_cmd_valid", bus.cmd_valid, 1'b1);
    check("w3_cmd_op", bus.cmd_opcode, 8'h03);
    check("w3_cmd_len", bus.cmd_length, 16'd3);
    check("w3_cmd_host", bus.cmd_host_addr, 40'h12_3456_7800);
    check("w3_cmd_local", bus.cmd_local_addr, 12'h0A0);
    @(negedge clk);
    #1;
    check("w3_cmd_hold", bus.cmd_valid, 1'b1);
    check("w3_cmd_hold_host", bus.cmd_host_addr, 40'h12_3456_7800);
    cmd_accept();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      bus.lsc_wr_valid = 1'b1;
      bus.lsc_wr_data  = beat(i);
      bus.c2h_ready    = 1'b1;
      #1;
      check("w3_c2h_valid", bus.c2h_valid, 1'b1);
      check("w3_c2h_data", bus.c2h_data, beat(i));
      if (bus.c2h_valid && bus.c2h_ready) n++;
      @(negedge clk);
    end
    bus.lsc_wr_data = beat(3);
    #1;
    check("w3_extra_valid", bus.c2h_valid, 1'b0);
    check("w3_extra_ready", bus.lsc_wr_ready, 1'b0);
    check("w3_done_busy", bus.busy, 1'b1);
    check("w3_beats", 32'(n), 32'd3);
    @(negedge clk);
    bus.lsc_wr_valid = 1'b0;
    bus.c2h_ready    = 1'b0;
    #1;
    check("w3_idle_busy", bus.busy, 1'b0);

    // Read, length 2
    start(OP_READ, 16'd2, 40'h00_0000_1000, 12'h010);
    after_hdr();
    check("r2_cmd_op", bus.cmd_opcode, 8'h01);
    check("r2_cmd_len", bus.cmd_length, 16'd2);
    bus.h2c_valid = 1'b1;
    bus.h2c_data  = {32{4'hA}};
    #1;
    check("r2_cmd_h2c_ready", bus.h2c_ready, 1'b0);
    cmd_accept();
    bus.lsc_rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.h2c_data = (i == 0) ? {32{4'hA}} : {32{4'hB}};
      #1;
      check("r2_rd_valid", bus.lsc_rd_valid, 1'b1);
      check("r2_rd_data", bus.lsc_rd_data, (i == 0) ? {32{4'hA}} : {32{4'hB}});
      check("r2_h2c_ready", bus.h2c_ready, 1'b1);
      @(negedge clk);
    end
    #1;
    check("r2_done_h2c_ready", bus.h2c_ready, 1'b0);
    check("r2_done_rd_valid", bus.lsc_rd_valid, 1'b0);
    check("r2_done_rd_data", bus.lsc_rd_data, 128'd0);
    bus.h2c_valid    = 1'b0;
    bus.lsc_rd_ready = 1'b0;
    @(negedge clk);

    // Write, length 4, with host backpressure
    start(OP_WRITE, 16'd4, 40'h00_ABCD_0000, 12'h100);
    after_hdr();
    cmd_accept();
    n = 0;
    for (int i = 0; i < 7; i++) begin
      bus.lsc_wr_valid = 1'b1;
      bus.lsc_wr_data  = beat(10 + n);
      bus.c2h_ready    = pat[i];
      #1;
      check("w4_wr_ready", bus.lsc_wr_ready, pat[i]);
      check("w4_c2h_data", bus.c2h_data, beat(10 + n));
      if (bus.c2h_valid && bus.c2h_ready) n++;
      @(negedge clk);
    end
    #1;
    check("w4_beats", 32'(n), 32'd4);
    check("w4_done_wr_ready", bus.lsc_wr_ready, 1'b0);
    check("w4_done_busy", bus.busy, 1'b1);
    bus.lsc_wr_valid = 1'b0;
    bus.c2h_ready    = 1'b0;
    @(negedge clk);

    // Illegal opcode
    start(8'h07, 16'd5, 40'h0, 12'h0);
    check("bad_err_pulse", bus.err_opcode, 1'b1);
    after_hdr();
    check("bad_err_clear", bus.err_opcode, 1'b0);
    check("bad_no_cmd", bus.cmd_valid, 1'b0);
    check("bad_done_busy", bus.busy, 1'b1);
    @(negedge clk);
    #1;
    check("bad_idle", bus.busy, 1'b0);

    // Length 0 read
    start(OP_READ, 16'd0, 40'h00_0000_2000, 12'h020);
    after_hdr();
    check("r0_cmd_valid", bus.cmd_valid, 1'b1);
    check("r0_cmd_len", bus.cmd_length, 16'd0);
    bus.h2c_valid    = 1'b1;
    bus.lsc_rd_ready = 1'b1;
    cmd_accept();
    #1;
    check("r0_no_rd_valid", bus.lsc_rd_valid, 1'b0);
    check("r0_no_h2c_ready", bus.h2c_ready, 1'b0);
    check("r0_done_busy", bus.busy, 1'b1);
    bus.h2c_valid    = 1'b0;
    bus.lsc_rd_ready = 1'b0;
    @(negedge clk);
    #1;
    check("r0_idle", bus.busy, 1'b0);

    // Reset in the middle of a length-8 write
    start(OP_WRITE, 16'd8, 40'h00_0000_3000, 12'h030);
    after_hdr();
    cmd_accept();
    bus.c2h_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.lsc_wr_valid = 1'b1;
      bus.lsc_wr_data  = beat(20 + i);
      @(negedge clk);
    end
    bus.lsc_wr_data = beat(23);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_c2h_valid", bus.c2h_valid, 1'b0);
    check("mrst_c2h_data", bus.c2h_data, 128'd0);
    check("mrst_wr_ready", bus.lsc_wr_ready, 1'b0);
    check("mrst_cmd_valid", bus.cmd_valid, 1'b0);
    check("mrst_err", bus.err_opcode, 1'b0);
    bus.lsc_wr_valid = 1'b0;
    bus.c2h_ready    = 1'b0;

    // Length 1 write after the reset
    start(OP_WRITE, 16'd1, 40'h00_0000_4000, 12'h040);
    after_hdr();
    check("w1_cmd_len", bus.cmd_length, 16'd1);
    check("w1_cmd_host", bus.cmd_host_addr, 40'h00_0000_4000);
    cmd_accept();
    bus.lsc_wr_valid = 1'b1;
    bus.lsc_wr_data  = beat(40);
    bus.c2h_ready    = 1'b1;
    #1;
    check("w1_c2h_valid", bus.c2h_valid, 1'b1);
    check("w1_c2h_data", bus.c2h_data, beat(40));
    @(negedge clk);
    #1;
    check("w1_done_valid", bus.c2h_valid, 1'b0);
    check("w1_done_busy", bus.busy, 1'b1);
    bus.lsc_wr_valid = 1'b0;
    bus.c2h_ready    = 1'b0;
    @(negedge clk);
    #1;
    check("w1_idle", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_path_ctrl.md
# dma_path_ctrl

Downstream stage of the FPU load/store controller. Grants one request at a time and decodes the 128-bit command header beat. Issues a host-side DMA command, then routes the payload in the direction the command gives:
- write (opcode 0x03): core stream to the host `c2h` stream;
- read (opcode 0x01): host `h2c` stream to the core read channel.

## Interface
Parameters: none. Data width is fixed at 128 and the header layout is fixed.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `lsc_req` in 1: transfer request; held until `lsc_resp`.
- `lsc_resp` out 1: one-cycle grant pulse.
- `lsc_wr_valid` in 1: header/payload beat valid from the core side.
- `lsc_wr_data` in 128: header/payload beat.
- `lsc_wr_ready` out 1: beat accepted when `lsc_wr_valid && lsc_wr_ready`.
- `lsc_rd_valid` out 1: read-return beat valid.
- `lsc_rd_data` out 128: read-return beat.
- `lsc_rd_ready` in 1: read-return backpressure.
- `cmd_valid` out 1: host command valid; held until `cmd_ready`.
- `cmd_ready` in 1: host command accept.
- `cmd_opcode` out 8: 0x01 read, 0x03 write.
- `cmd_length` out 16: beat count.
- `cmd_host_addr` out 40: host byte address.
- `cmd_local_addr` out 12: local buffer address.
- `c2h_valid` out 1, `c2h_data` out 128, `c2h_ready` in 1: payload to host.
- `h2c_valid` in 1, `h2c_data` in 128, `h2c_ready` out 1: payload from host.
- `busy` out 1: high in every state except IDLE.
- `err_opcode` out 1: one-cycle pulse when a header carries an illegal opcode.

## Operation
Header beat fields:
- [127:80] ignored;
- [79:72] opcode;
- [71:56] length;
- [55:16] host_addr;
- [15:12] ignored;
- [11:0] local_addr.

FSM states: IDLE, GRANT, HDR, CMD, WR_DATA, RD_DATA, DONE.
- IDLE: when `lsc_req`=1, go to GRANT.
- GRANT: `lsc_resp`=1 for this cycle only; go to HDR.
- HDR: `lsc_wr_ready`=1. On a handshake, register opcode, length, host_addr and local_addr.
  - Opcode 0x01 or 0x03: go to CMD.
  - Any other opcode: pulse `err_opcode` and go to DONE; no command is issued.
- CMD: `cmd_valid`=1 with the registered fields, stable until `cmd_ready`.
  - On handshake: if length==0, go to DONE.
  - Otherwise go to WR_DATA (0x03) or RD_DATA (0x01).
- WR_DATA: combinational pass-through.
  - `c2h_valid = lsc_wr_valid`; `c2h_data = lsc_wr_data`; `lsc_wr_ready = c2h_ready`.
  - Count handshakes; after beat number `length`, go to DONE.
- RD_DATA: combinational pass-through.
  - `lsc_rd_valid = h2c_valid`; `lsc_rd_data = h2c_data`; `h2c_ready = lsc_rd_ready`.
  - Count handshakes; after beat number `length`, go to DONE.
- DONE: one cycle, then IDLE. `lsc_req` is not sampled in DONE.

Beat counter:
- 16-bit, cleared when leaving HDR.
- Terminal test is `cnt+1 == length` on a handshake, so length 0xFFFF gives 65535 beats with no wrap.

Outside its active state, each stream's valid and ready are 0. Beats beyond `length` are therefore never accepted.

## Timing
- Reset values: every output is 0; FSM=IDLE; counter and field registers are 0. `lsc_rd_data` and `c2h_data` read 0 when not passing through.
- `lsc_req` seen high in IDLE at edge N gives `lsc_resp` high during cycle N+1; the earliest header handshake is in cycle N+2.
- Header accepted at edge M gives `cmd_valid` high from cycle M+1.
- The payload paths add zero latency. Throughput is one beat per cycle when both sides are ready.
- Back-to-back transfers: DONE→IDLE→GRANT, so there are at least 2 idle cycles between the last beat and the next `lsc_resp`.
- `rst` asserted mid-transfer: at the next edge the FSM returns to IDLE and all outputs drop to 0. In-flight beats and any pending command are discarded; no `err_opcode` pulse.
- `err_opcode` and `lsc_resp` never assert in the same cycle.

## Structure
- Package `dma_pkg`:
  - `OP_READ`=8'h01, `OP_WRITE`=8'h03;
  - header field MSB/LSB constants;
  - the FSM state localparams (4-bit encoding).
- Sub-module `dma_hdr_decode`: combinational. Takes the 128-bit beat and outputs opcode, length, host_addr, local_addr and `op_legal`. Shared with the load/store controller's header builder for cross-checking.
- The top level holds the FSM, the counter, the field registers and the stream muxing.

## Test plan
- Write, length 3, host 0x12_3456_7800, local 0x0A0, `c2h_ready`=1: `cmd` shows opcode 0x03, length 3 and those addresses. Exactly 3 `c2h` beats equal the input data; `busy` falls 2 cycles after the last beat.
- Read, length 2, `lsc_rd_ready`=1, `h2c_valid` high for 2 beats (0xAA.., 0xBB..): `lsc_rd_data` shows the same values in the same cycles; `h2c_ready` falls after beat 2.
- Write, length 4, with `c2h_ready` toggled 1,0,0,1,1,0,1: no beat is lost or duplicated; the counter reaches 4 only on ready cycles.
- Header with opcode 0x07: `err_opcode` pulses once; `cmd_valid` stays 0; FSM returns to IDLE.
- Length 0 read: `cmd` handshake, then DONE with no `lsc_rd_valid`. Then assert `rst` for 1 cycle in the middle of a length-8 write after 3 beats: all outputs 0 on the next cycle; a following write with length 1 completes normally.
